// File: rtl/arb_pkg.sv
// Shared types and the rotating priority search for the round-robin arbiter.
package arb_pkg;

    localparam int unsigned MaxN    = 16;
    localparam int unsigned MaxIdxW = 4;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_OWN
    } arb_state_e;

    typedef struct packed {
        logic               found;
        logic [MaxIdxW-1:0] idx;
    } pick_t;

    // First set bit of elig & ~excl, scanning from start and wrapping at n.
    function automatic pick_t rr_pick(input logic [MaxN-1:0]    elig,
                                      input logic [MaxIdxW-1:0] start,
                                      input logic [MaxN-1:0]    excl,
                                      input int unsigned        n);
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            if (i < n) begin
                // start < n and i < n, so one conditional subtract is a full modulo
                j = 32'(start) + i;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && elig[j[MaxIdxW-1:0]] && !excl[j[MaxIdxW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[MaxIdxW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating priority search over N clients with an exclusion mask.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         elig_i,
    input  logic [$clog2(N)-1:0] start_i,
    input  logic [N-1:0]         excl_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(N);

    pick_t res;

    // Widen to the package search width and pick the winner.
    always_comb begin
        res = rr_pick(MaxN'(elig_i), MaxIdxW'(start_i), MaxN'(excl_i), N);
    end

    assign found_o = res.found;
    assign idx_o   = IdxW'(res.idx);

endmodule

// File: rtl/arb_rr_grant.sv
// Registered N-client arbiter: fixed or round-robin policy, grant hold, hold-limit timeout.
module arb_rr_grant
    import arb_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned RR       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         en,
    output logic [N-1:0]         gnt,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int unsigned     IdxW     = $clog2(N);
    localparam int unsigned     HoldW    = $clog2(HOLD_MAX + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX - 1);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(HOLD_MAX);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N - 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IdxW-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [HoldW-1:0] hold_q, hold_d;

    logic [N-1:0]    elig;
    logic [N-1:0]    excl;
    logic [IdxW-1:0] start;
    logic            own_keep;
    logic            others;
    logic            expire;
    logic            arb;
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;

    assign elig = req & en;

    // Policy inputs: owner status, contention, hold expiry and search start.
    always_comb begin
        own_keep = |(elig & gnt_q);
        others   = |(elig & ~gnt_q);
        // A release in the same cycle wins over expiry, hence own_keep here
        expire   = (state_q == ARB_OWN) && own_keep && others && (hold_q == HoldLast);
        excl     = expire ? gnt_q : '0;
        if (RR != 0) begin
            start = (last_q == LastIdx) ? '0 : last_q + 1'b1;
        end else begin
            start = '0;
        end
        arb = (state_q == ARB_IDLE) || !own_keep || expire;
    end

    arb_pick #(
        .N (N)
    ) u_pick (
        .elig_i  (elig),
        .start_i (start),
        .excl_i  (excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // State register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= LastIdx;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    // Next state and hold counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (arb) begin
            state_d = pick_found ? ARB_OWN : ARB_IDLE;
            hold_d  = '0;
        end else if (others) begin
            if (hold_q != HoldSat) begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            hold_d = '0;
        end
    end

    // Grant outputs and round-robin pointer for the next cycle.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        if (arb) begin
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
            if (pick_found) begin
                gnt_d[pick_idx] = 1'b1;
                gnt_id_d        = pick_idx;
                gnt_vld_d       = 1'b1;
                last_d          = pick_idx;
                timeout_d       = expire;
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_rr_grant.sv
// Scoreboard bench: a round-robin and a fixed-priority instance, N=3, HOLD_MAX=4.
module tb_arb_rr_grant;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req_rr, en_rr, req_fp, en_fp;
    logic [2:0] gnt_rr, gnt_fp;
    logic [1:0] id_rr, id_fp;
    logic       vld_rr, vld_fp, tmo_rr, tmo_fp;

    arb_rr_grant #(
        .N        (3),
        .HOLD_MAX (4),
        .RR       (1)
    ) dut_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_rr),
        .en      (en_rr),
        .gnt     (gnt_rr),
        .gnt_vld (vld_rr),
        .gnt_id  (id_rr),
        .timeout (tmo_rr)
    );

    arb_rr_grant #(
        .N        (3),
        .HOLD_MAX (4),
        .RR       (0)
    ) dut_fp (
        .clk     (clk),
        .rst     (rst),
        .req     (req_fp),
        .en      (en_fp),
        .gnt     (gnt_fp),
        .gnt_vld (vld_fp),
        .gnt_id  (id_fp),
        .timeout (tmo_fp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         sel;
        string      name;
        logic [2:0] gnt;
        logic       tmo;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] act, want;
    event       imm_ev;

    function automatic logic [1:0] oh2id(input logic [2:0] g);
        if (g[1]) return 2'd1;
        if (g[2]) return 2'd2;
        return 2'd0;
    endfunction

    // Monitor: compare every expectation that has come due.
    always @(negedge clk or imm_ev) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur  = sb.pop_front();
            act  = (cur.sel == 0) ? {gnt_rr, id_rr, vld_rr, tmo_rr}
                                  : {gnt_fp, id_fp, vld_fp, tmo_fp};
            want = {cur.gnt, oh2id(cur.gnt), |cur.gnt, cur.tmo};
            n_vec++;
            if (cur.due < cyc || act !== want) begin
                n_err++;
                $display("FAIL %s (dut %0d, cycle %0d): got gnt=%b id=%0d vld=%b tmo=%b, want gnt=%b id=%0d vld=%b tmo=%b",
                         cur.name, cur.sel, cyc, act[6:4], act[3:2], act[1], act[0],
                         want[6:4], want[3:2], want[1], want[0]);
            end
        end
    end

    // Drive one cycle of inputs to one instance and expect its output after the next edge.
    task automatic step(input string name, input int sel, input logic [2:0] r,
                        input logic [2:0] e, input logic [2:0] g, input logic t);
        if (sel == 0) begin
            req_rr = r;
            en_rr  = e;
            req_fp = 3'b000;
            en_fp  = 3'b111;
        end else begin
            req_fp = r;
            en_fp  = e;
            req_rr = 3'b000;
            en_rr  = 3'b111;
        end
        sb.push_back('{cyc + 1, sel, name, g, t});
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from any edge, expect cleared outputs at once, release after an edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.push_back('{cyc, 0, name, 3'b000, 1'b0});
        sb.push_back('{cyc, 1, name, 3'b000, 1'b0});
        ->imm_ev;
        #1;
        req_rr = 3'b000;
        req_fp = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        req_rr = 3'b000;
        en_rr  = 3'b111;
        req_fp = 3'b000;
        en_fp  = 3'b111;

        do_reset("reset");
        step("idle", 0, 3'b000, 3'b111, 3'b000, 1'b0);

        // Round-robin rotation, each owner releasing after two cycles
        step("rr_g0a", 0, 3'b111, 3'b111, 3'b001, 1'b0);
        step("rr_g0b", 0, 3'b111, 3'b111, 3'b001, 1'b0);
        step("rr_g1a", 0, 3'b110, 3'b111, 3'b010, 1'b0);
        step("rr_g1b", 0, 3'b110, 3'b111, 3'b010, 1'b0);
        step("rr_g2a", 0, 3'b101, 3'b111, 3'b100, 1'b0);
        step("rr_g2b", 0, 3'b101, 3'b111, 3'b100, 1'b0);
        step("rr_g0c", 0, 3'b011, 3'b111, 3'b001, 1'b0);
        step("rr_g0d", 0, 3'b011, 3'b111, 3'b001, 1'b0);
        step("rr_drop", 0, 3'b000, 3'b111, 3'b000, 1'b0);

        // Hold limit with two contending clients
        do_reset("reset_hold");
        for (int i = 0; i < 4; i++) step("hold_c0", 0, 3'b011, 3'b111, 3'b001, 1'b0);
        step("tmo_to1", 0, 3'b011, 3'b111, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_c1", 0, 3'b011, 3'b111, 3'b010, 1'b0);
        step("tmo_to0", 0, 3'b011, 3'b111, 3'b001, 1'b1);
        step("tmo_once", 0, 3'b011, 3'b111, 3'b001, 1'b0);
        step("hold_drop", 0, 3'b000, 3'b111, 3'b000, 1'b0);

        // Fixed priority: late low-index request waits for timeout, then beats client 2
        do_reset("reset_fp");
        step("fp_g1", 1, 3'b110, 3'b111, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) step("fp_hold1", 1, 3'b111, 3'b111, 3'b010, 1'b0);
        step("fp_tmo0", 1, 3'b111, 3'b111, 3'b001, 1'b1);
        step("fp_drop", 1, 3'b000, 3'b111, 3'b000, 1'b0);
        // Fixed priority: owner release hands over to the lowest index
        step("fp_g1r", 1, 3'b110, 3'b111, 3'b010, 1'b0);
        step("fp_keep1", 1, 3'b111, 3'b111, 3'b010, 1'b0);
        step("fp_rel0", 1, 3'b101, 3'b111, 3'b001, 1'b0);
        step("fp_drop2", 1, 3'b000, 3'b111, 3'b000, 1'b0);

        // Masked requester is never granted
        step("mask_a", 0, 3'b010, 3'b101, 3'b000, 1'b0);
        step("mask_b", 0, 3'b010, 3'b101, 3'b000, 1'b0);

        // Release in the cycle the hold counter reaches its limit
        do_reset("reset_relx");
        for (int i = 0; i < 4; i++) step("relx_c0", 0, 3'b011, 3'b111, 3'b001, 1'b0);
        step("relx_no_tmo", 0, 3'b010, 3'b111, 3'b010, 1'b0);
        step("relx_drop", 0, 3'b000, 3'b111, 3'b000, 1'b0);

        // Asynchronous reset while client 2 owns
        step("own2a", 0, 3'b100, 3'b111, 3'b100, 1'b0);
        step("own2b", 0, 3'b100, 3'b111, 3'b100, 1'b0);
        do_reset("async_rst");
        step("post_rst_g0", 0, 3'b111, 3'b111, 3'b001, 1'b0);
        step("post_rst_keep", 0, 3'b111, 3'b111, 3'b001, 1'b0);
        step("en_drop_rel", 0, 3'b111, 3'b110, 3'b010, 1'b0);
        step("final_drop", 0, 3'b000, 3'b111, 3'b000, 1'b0);

        @(posedge clk);
        @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
